// File: rtl/fp16_pkg.sv
// Shared constants and FSM encoding for the simplified FP16 datapath
// (hidden-1 significands, bias 15, no subnormals/NaN, truncation).
package fp16_pkg;

   localparam int FP16_BIAS    = 15;
   localparam int FP16_EXP_MAX = 30;
   localparam int FP16_ITER    = 12;
   localparam logic [14:0] FP16_INF = 15'h7C00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_NORM   = 2'd2
   } div_state_t;

endpackage

// File: rtl/fp16_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module fp16_div_step
   import fp16_pkg::*;
(
   input  logic [FP16_ITER-1:0] rem,
   input  logic [FP16_ITER-2:0] dvs,
   output logic                 qbit,
   output logic [FP16_ITER-1:0] rem_next
);

   logic [FP16_ITER-1:0] dvs_ext;
   logic [FP16_ITER-1:0] diff;

   // The remainder always stays below twice the divisor, so the shifted value fits.
   always_comb begin
      dvs_ext  = {1'b0, dvs};
      diff     = rem - dvs_ext;
      qbit     = (rem >= dvs_ext);
      rem_next = qbit ? {diff[FP16_ITER-2:0], 1'b0} : {rem[FP16_ITER-2:0], 1'b0};
   end

endmodule

// File: rtl/fp16_divider_seq.sv
// Sequential FP16 divider: one quotient bit per clock, start/busy/done handshake.
module fp16_divider_seq
   import fp16_pkg::*;
#(
   parameter int BIAS = FP16_BIAS,
   parameter int ITER = FP16_ITER
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] inp1,
   input  logic [15:0] inp2,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        overflow,
   output logic        underflow,
   output logic        divzero
);

   localparam int CW = $clog2(ITER);
   localparam logic signed [6:0] BIAS7    = 7'(BIAS);
   localparam logic signed [6:0] EXP_MAX7 = 7'(FP16_EXP_MAX);

   div_state_t        state;
   logic              sign;
   logic [11:0]       rem;
   logic [10:0]       dvs;
   logic [11:0]       quo;
   logic signed [6:0] ediff;
   logic [CW-1:0]     cnt;
   logic              zero_dvs;
   logic              zero_dvd;

   logic              qbit;
   logic [11:0]       rem_next;
   logic signed [6:0] ediff_in;
   logic signed [6:0] e_adj;
   logic [9:0]        mant;

   fp16_div_step u_step (
      .rem      (rem),
      .dvs      (dvs),
      .qbit     (qbit),
      .rem_next (rem_next)
   );

   // Quotient lies in (0.5, 2): a clear integer bit means one normalising shift.
   always_comb begin
      ediff_in = $signed({2'b00, inp1[14:10]}) - $signed({2'b00, inp2[14:10]}) + BIAS7;
      e_adj    = quo[11] ? ediff : ediff - 7'sd1;
      mant     = quo[11] ? quo[10:1] : quo[9:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= 16'h0000;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         divzero   <= 1'b0;
         cnt       <= '0;
         rem       <= '0;
         dvs       <= '0;
         quo       <= '0;
         ediff     <= '0;
         sign      <= 1'b0;
         zero_dvs  <= 1'b0;
         zero_dvd  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sign     <= inp1[15] ^ inp2[15];
                  rem      <= {1'b0, 1'b1, inp1[9:0]};
                  dvs      <= {1'b1, inp2[9:0]};
                  ediff    <= ediff_in;
                  cnt      <= CW'(ITER - 1);
                  quo      <= '0;
                  busy     <= 1'b1;
                  zero_dvs <= (inp2[14:0] == 15'h0000);
                  zero_dvd <= (inp1[14:0] == 15'h0000);
                  state    <= ((inp2[14:0] == 15'h0000) || (inp1[14:0] == 15'h0000))
                              ? ST_NORM : ST_DIVIDE;
               end
            end
            ST_DIVIDE: begin
               rem <= rem_next;
               quo <= {quo[10:0], qbit};
               cnt <= cnt - 1'b1;
               if (cnt == '0)
                  state <= ST_NORM;
            end
            ST_NORM: begin
               overflow  <= 1'b0;
               underflow <= 1'b0;
               divzero   <= 1'b0;
               if (zero_dvs) begin
                  result  <= {sign, FP16_INF};
                  divzero <= 1'b1;
               end else if (zero_dvd) begin
                  result <= {sign, 15'h0000};
               end else if (e_adj > EXP_MAX7) begin
                  result   <= {sign, FP16_INF};
                  overflow <= 1'b1;
               end else if (e_adj < 7'sd1) begin
                  result    <= {sign, 15'h0000};
                  underflow <= 1'b1;
               end else begin
                  result <= {sign, e_adj[4:0], mant};
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_divider_seq.sv
// Directed self-checking bench for fp16_divider_seq with hand-computed quotients.
module tb_fp16_divider_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] inp1;
   logic [15:0] inp2;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow;
   logic        underflow;
   logic        divzero;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int lat   = 0;

   fp16_divider_seq dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inp1      (inp1),
      .inp2      (inp2),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .divzero   (divzero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Launch an operation; the accepting edge is recorded in t0.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit at_negedge);
      if (at_negedge) @(negedge clk);
      inp1  = a;
      inp2  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (done !== 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL %s timeout observed=no_done expected=done", tag);
      end
      lat = cyc - t0;
   endtask

   task automatic checkOutput(input string tag, input int exp_lat, input logic [15:0] r,
                              input logic ov, input logic un, input logic dz);
      waitDone(tag);
      check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
      check({tag, "_res"}, result, r);
      check({tag, "_flags"}, {13'b0, overflow, underflow, divzero}, {13'b0, ov, un, dz});
      check({tag, "_busy"}, {15'b0, busy}, 16'h0000);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      inp1  = 16'h0000;
      inp2  = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {15'b0, busy}, 16'h0000);
      check("rst_done", {15'b0, done}, 16'h0000);
      check("rst_res", result, 16'h0000);
      check("rst_flags", {13'b0, overflow, underflow, divzero}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(16'h4200, 16'h3E00, 1'b1);
      check("busy_after_start", {15'b0, busy}, 16'h0001);
      checkOutput("three_by_1p5", 13, 16'h4000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("done_pulse", {15'b0, done}, 16'h0000);

      applyStimulus(16'h3C00, 16'h4200, 1'b1);
      checkOutput("one_third", 13, 16'h3555, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h4500, 16'h4200, 1'b1);
      checkOutput("five_thirds", 13, 16'h3EAA, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'hC600, 16'h4000, 1'b1);
      checkOutput("neg_six_by_two", 13, 16'hC200, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h4000, 16'h0000, 1'b1);
      checkOutput("div_by_zero", 1, 16'h7C00, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'h0000, 16'h8000, 1'b1);
      checkOutput("zero_by_zero", 1, 16'hFC00, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'h4000, 1'b1);
      checkOutput("zero_dividend", 1, 16'h8000, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h7800, 16'h3C00, 1'b1);
      checkOutput("exp_max_edge", 13, 16'h7800, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0400, 16'h3C00, 1'b1);
      checkOutput("exp_min_edge", 13, 16'h0400, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0400, 16'h3E00, 1'b1);
      checkOutput("norm_underflow", 13, 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'h7800, 16'h0400, 1'b1);
      checkOutput("overflow", 13, 16'h7C00, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0400, 16'h7800, 1'b1);
      checkOutput("underflow", 13, 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(16'hF800, 16'h0400, 1'b1);
      checkOutput("neg_overflow", 13, 16'hFC00, 1'b1, 1'b0, 1'b0);

      // Back-to-back: new start issued in the done cycle.
      applyStimulus(16'h4200, 16'h3E00, 1'b1);
      checkOutput("b2b_first", 13, 16'h4000, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h3C00, 16'h4200, 1'b0);
      checkOutput("b2b_second", 13, 16'h3555, 1'b0, 1'b0, 1'b0);

      // A start pulse mid-divide with different operands must be ignored.
      applyStimulus(16'h4200, 16'h3E00, 1'b1);
      repeat (3) @(negedge clk);
      inp1  = 16'h4000;
      inp2  = 16'h0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_while_busy", 13, 16'h4000, 1'b0, 1'b0, 1'b0);

      // Leave flags set, then reset partway into the next divide.
      applyStimulus(16'h7800, 16'h0400, 1'b1);
      checkOutput("pre_reset_ovf", 13, 16'h7C00, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h4200, 16'h3E00, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_busy", {15'b0, busy}, 16'h0000);
      check("midrst_done", {15'b0, done}, 16'h0000);
      check("midrst_res", result, 16'h0000);
      check("midrst_flags", {13'b0, overflow, underflow, divzero}, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      begin
         logic seen = 1'b0;
         repeat (16) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
         end
         check("midrst_no_done", {15'b0, seen}, 16'h0000);
      end
      applyStimulus(16'h3C00, 16'h4200, 1'b1);
      checkOutput("post_reset", 13, 16'h3555, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
